// File: rtl/i2c_pad_pkg.sv
// rtl/i2c_pad_pkg.sv - shared constants for the I2C pad conditioner
package i2c_pad_pkg;

    localparam int FILTER_CNT_W         = 4;
    localparam int DEFAULT_FILTER_LEN   = 4;
    localparam int DEFAULT_STUCK_CYCLES = 50000;

    localparam int SCL_IO = 5;
    localparam int SDA_IO = 6;

endpackage

// File: rtl/i2c_glitch_filter.sv
// rtl/i2c_glitch_filter.sv - two-flop synchroniser plus level-acceptance glitch filter for one line
module i2c_glitch_filter
    import i2c_pad_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic pad,
    output logic level
);

    localparam logic [FILTER_CNT_W-1:0] CNT_LAST = FILTER_CNT_W'(FILTER_LEN - 1);

    logic [1:0]              sync;
    logic                    filtered;
    logic [FILTER_CNT_W-1:0] cnt;

    // The synchroniser keeps running while disabled so a re-enable sees the live pad level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            filtered <= 1'b1;
            cnt      <= '0;
        end else begin
            sync <= {sync[0], pad};
            if (!enable) begin
                filtered <= 1'b1;
                cnt      <= '0;
            end else if (sync[1] != filtered) begin
                if (cnt == CNT_LAST) begin
                    filtered <= sync[1];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = filtered | ~enable;

endmodule

// File: rtl/i2c_pad_conditioner.sv
// rtl/i2c_pad_conditioner.sv - I2C pad conditioning: open-drain drive, filtered inputs, START/STOP and stuck-bus monitor
module i2c_pad_conditioner
    import i2c_pad_pkg::*;
#(
    parameter int FILTER_LEN   = DEFAULT_FILTER_LEN,
    parameter int STUCK_CYCLES = DEFAULT_STUCK_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic scl_pad_o,
    output logic scl_pad_oeb_o,
    output logic sda_pad_o,
    output logic sda_pad_oeb_o,
    input  logic scl_m_o,
    input  logic scl_m_oen,
    input  logic sda_m_o,
    input  logic sda_m_oen,
    output logic scl_m_i,
    output logic sda_m_i,
    output logic start_det_o,
    output logic stop_det_o,
    output logic bus_busy_o,
    output logic stuck_o,
    input  logic stuck_clr_i
);

    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES);

    logic             scl_f;
    logic             sda_f;
    logic             scl_q;
    logic             sda_q;
    logic             start_cond;
    logic             stop_cond;
    logic             line_low;
    logic             stuck_set;
    logic [CNT_W-1:0] stuck_cnt;

    // Open drain: only ever pull low; reset releases the pads without waiting for a clock.
    assign scl_pad_o     = 1'b0;
    assign sda_pad_o     = 1'b0;
    assign scl_pad_oeb_o = ~(rst_n_i & enable_i & scl_m_oen & ~scl_m_o);
    assign sda_pad_oeb_o = ~(rst_n_i & enable_i & sda_m_oen & ~sda_m_o);

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .enable (enable_i),
        .pad    (scl_pad_i),
        .level  (scl_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .enable (enable_i),
        .pad    (sda_pad_i),
        .level  (sda_f)
    );

    assign scl_m_i = scl_f;
    assign sda_m_i = sda_f;

    // SCL must be high both before and after the SDA edge, so simultaneous edges never qualify.
    assign start_cond = scl_q & scl_f & sda_q & ~sda_f;
    assign stop_cond  = scl_q & scl_f & ~sda_q & sda_f;
    assign line_low   = ~scl_f | ~sda_f;
    assign stuck_set  = enable_i & ~stuck_clr_i & line_low & (stuck_cnt == STUCK_MAX - 1'b1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            bus_busy_o  <= 1'b0;
        end else begin
            scl_q       <= scl_f;
            sda_q       <= sda_f;
            start_det_o <= enable_i & start_cond;
            stop_det_o  <= enable_i & stop_cond;
            if (!enable_i || stuck_set) begin
                bus_busy_o <= 1'b0;
            end else if (start_cond) begin
                bus_busy_o <= 1'b1;
            end else if (stop_cond) begin
                bus_busy_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stuck_cnt <= '0;
            stuck_o   <= 1'b0;
        end else if (stuck_clr_i) begin
            stuck_cnt <= '0;
            stuck_o   <= 1'b0;
        end else if (!enable_i) begin
            stuck_cnt <= '0;
        end else if (line_low) begin
            if (stuck_cnt != STUCK_MAX) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
            if (stuck_set) begin
                stuck_o <= 1'b1;
            end
        end else begin
            stuck_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// tb/tb_i2c_pad_conditioner.sv - self-checking bench for i2c_pad_conditioner
module tb_i2c_pad_conditioner;

    localparam int FL = 4;
    localparam int SC = 100;

    typedef struct {
        logic en;
        logic scl_o;
        logic scl_oen;
        logic sda_o;
        logic sda_oen;
        logic exp_scl_oeb;
        logic exp_sda_oeb;
    } pad_vec_t;

    logic clk = 1'b0;
    logic rst_n, enable, scl_pad_i, sda_pad_i;
    logic scl_pad_o, scl_pad_oeb, sda_pad_o, sda_pad_oeb;
    logic scl_m_o, scl_m_oen, sda_m_o, sda_m_oen;
    logic scl_m_i, sda_m_i, start_det, stop_det, bus_busy, stuck, stuck_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_pad_conditioner #(.FILTER_LEN(FL), .STUCK_CYCLES(SC), .CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .scl_pad_i     (scl_pad_i),
        .sda_pad_i     (sda_pad_i),
        .scl_pad_o     (scl_pad_o),
        .scl_pad_oeb_o (scl_pad_oeb),
        .sda_pad_o     (sda_pad_o),
        .sda_pad_oeb_o (sda_pad_oeb),
        .scl_m_o       (scl_m_o),
        .scl_m_oen     (scl_m_oen),
        .sda_m_o       (sda_m_o),
        .sda_m_oen     (sda_m_oen),
        .scl_m_i       (scl_m_i),
        .sda_m_i       (sda_m_i),
        .start_det_o   (start_det),
        .stop_det_o    (stop_det),
        .bus_busy_o    (bus_busy),
        .stuck_o       (stuck),
        .stuck_clr_i   (stuck_clr)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    pad_vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; enable = 1'b1; scl_pad_i = 1'b1; sda_pad_i = 1'b1;
        scl_m_o = 1'b0; scl_m_oen = 1'b1; sda_m_o = 1'b0; sda_m_oen = 1'b0;
        stuck_clr = 1'b0;

        // Reset state, with the master trying to drive SCL low
        repeat (3) tick();
        check("rst_scl_oeb", scl_pad_oeb, 1'b1);
        check("rst_sda_oeb", sda_pad_oeb, 1'b1);
        check("rst_scl_o", scl_pad_o, 1'b0);
        check("rst_scl_m_i", scl_m_i, 1'b1);
        check("rst_sda_m_i", sda_m_i, 1'b1);
        check("rst_start", start_det, 1'b0);
        check("rst_stop", stop_det, 1'b0);
        check("rst_busy", bus_busy, 1'b0);
        check("rst_stuck", stuck, 1'b0);
        scl_m_oen = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();

        // Glitch filter: 3-cycle pulse suppressed, 4-cycle pulse accepted 6 cycles after pad edge
        scl_pad_i = 1'b0;
        repeat (3) tick();
        scl_pad_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("glitch3_scl", scl_m_i, 1'b1);
        end
        scl_pad_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) scl_pad_i = 1'b1;
            check("pulse4_scl", scl_m_i, !(k >= 6 && k <= 9));
            check("pulse4_nostart", start_det, 1'b0);
        end
        repeat (3) tick();

        // START then STOP
        sda_pad_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("start_sda", sda_m_i, !(k >= 6));
            check("start_pulse", start_det, k == 7);
            check("start_busy", bus_busy, k >= 7);
        end
        sda_pad_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("stop_sda", sda_m_i, k >= 6);
            check("stop_pulse", stop_det, k == 7);
            check("stop_busy", bus_busy, k < 7);
        end

        // Both lines fall together: no START
        scl_pad_i = 1'b0; sda_pad_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("simul_nostart", start_det, 1'b0);
            check("simul_busy", bus_busy, 1'b0);
        end
        check("simul_scl_low", scl_m_i, 1'b0);
        check("simul_sda_low", sda_m_i, 1'b0);
        scl_pad_i = 1'b1; sda_pad_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("simul_nostop", stop_det, 1'b0);
        end

        // Open-drain pad control table
        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            scl_m_o = vecs[i].scl_o; scl_m_oen = vecs[i].scl_oen;
            sda_m_o = vecs[i].sda_o; sda_m_oen = vecs[i].sda_oen;
            #1;
            check("tbl_scl_oeb", scl_pad_oeb, vecs[i].exp_scl_oeb);
            check("tbl_sda_oeb", sda_pad_oeb, vecs[i].exp_sda_oeb);
            check("tbl_scl_o", scl_pad_o, 1'b0);
            check("tbl_sda_o", sda_pad_o, 1'b0);
        end
        enable = 1'b1; scl_m_oen = 1'b0; sda_m_oen = 1'b0;
        repeat (3) tick();

        // Stuck SDA: START, then stuck after 100 filtered-low cycles clears busy
        sda_pad_i = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            tick();
            check("stuck_rise", stuck, k >= 106);
            check("stuck_busy", bus_busy, k >= 7 && k < 106);
        end
        stuck_clr = 1'b1;
        tick();
        check("stuck_clr", stuck, 1'b0);
        stuck_clr = 1'b0;
        for (int j = 1; j <= 101; j++) begin
            tick();
            check("stuck_reassert", stuck, j >= 100);
        end
        stuck_clr = 1'b1; sda_pad_i = 1'b1;
        tick();
        stuck_clr = 1'b0;
        repeat (12) tick();
        check("stuck_released", stuck, 1'b0);
        check("stuck_sda_high", sda_m_i, 1'b1);

        // Asynchronous reset mid-transfer
        scl_m_oen = 1'b1; scl_m_o = 1'b0;
        sda_pad_i = 1'b0;
        repeat (7) tick();
        check("pre_rst_busy", bus_busy, 1'b1);
        check("pre_rst_oeb", scl_pad_oeb, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_oeb", scl_pad_oeb, 1'b1);
        check("arst_busy", bus_busy, 1'b0);
        check("arst_sda_m_i", sda_m_i, 1'b1);
        sda_pad_i = 1'b1; scl_m_oen = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_busy", bus_busy, 1'b0);
        check("post_rst_sda", sda_m_i, 1'b1);

        // Enable dropped mid-transfer, then resumed with SDA still low
        scl_m_oen = 1'b1; scl_m_o = 1'b0;
        sda_pad_i = 1'b0;
        repeat (8) tick();
        check("pre_dis_busy", bus_busy, 1'b1);
        check("pre_dis_oeb", scl_pad_oeb, 1'b0);
        check("pre_dis_sda", sda_m_i, 1'b0);
        enable = 1'b0;
        #1;
        check("dis_oeb", scl_pad_oeb, 1'b1);
        check("dis_sda_m_i", sda_m_i, 1'b1);
        check("dis_scl_m_i", scl_m_i, 1'b1);
        tick();
        check("dis_busy", bus_busy, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            tick();
            check("dis_nostuck", stuck, 1'b0);
            check("dis_nostart", start_det, 1'b0);
        end
        scl_m_oen = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 104; k++) begin
            tick();
            if (k <= 5) check("reen_sda", sda_m_i, !(k >= 4));
            if (k <= 6) check("reen_start", start_det, k == 5);
            if (k >= 100) check("reen_stuck", stuck, k >= 104);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_pad_conditioner.md
Name: i2c_pad_conditioner

Overview:
- Sits between the Caravel I2C pads (io 5 = SCL, io 6 = SDA) and the I2C master core.
- Inbound path: synchronises and glitch-filters SCL/SDA, then presents clean scl_i/sda_i to the master.
- Outbound path: converts the master's o/oen pairs into true open-drain pad controls.
- Monitor: detects START/STOP, tracks bus busy, and flags a stuck-low bus as an interrupt source.

Parameters:
- FILTER_LEN, 4, consecutive synchronised cycles a new level must hold before it is accepted (2..15).
- STUCK_CYCLES, 50000, cycles either line may stay low before stuck_o asserts.
- CNT_W, 16, stuck counter width; must satisfy 2^CNT_W > STUCK_CYCLES.

Ports:
- clk_i  in  1  block clock (wb_clk_i at top).
- rst_n_i  in  1  reset; asynchronous, active-low.
- enable_i  in  1  block enable.
- scl_pad_i  in  1  raw SCL from io_in[5].
- sda_pad_i  in  1  raw SDA from io_in[6].
- scl_pad_o  out  1  to io_out[5].
- scl_pad_oeb_o  out  1  to io_oeb[5], active-low output enable.
- sda_pad_o  out  1  to io_out[6].
- sda_pad_oeb_o  out  1  to io_oeb[6], active-low output enable.
- scl_m_o  in  1  master SCL output value.
- scl_m_oen  in  1  master SCL output enable, 1 = drive.
- sda_m_o  in  1  master SDA output value.
- sda_m_oen  in  1  master SDA output enable, 1 = drive.
- scl_m_i  out  1  filtered SCL to master.
- sda_m_i  out  1  filtered SDA to master.
- start_det_o  out  1  one-cycle pulse on START.
- stop_det_o  out  1  one-cycle pulse on STOP.
- bus_busy_o  out  1  high between START and STOP.
- stuck_o  out  1  sticky stuck-bus flag, usable as an IRQ.
- stuck_clr_i  in  1  clears stuck_o.

Behaviour:
- Reset values:
  - Sync flops and filtered levels = 1; scl_m_i = sda_m_i = 1.
  - scl_pad_o = sda_pad_o = 0 (constant).
  - scl_pad_oeb_o = sda_pad_oeb_o = 1.
  - start_det_o = stop_det_o = bus_busy_o = stuck_o = 0.
  - All counters = 0.
- Open-drain output:
  - pad_o is always 0.
  - pad_oeb = ~(enable_i & m_oen & ~m_o), combinational.
  - The pad is driven low only when the master enables the line with value 0; otherwise it is released.
- Synchroniser: 2 flops per line.
- Glitch filter (per line):
  - 4-bit counter.
  - If sync != filtered, the counter increments.
  - When counter == FILTER_LEN-1 and still mismatched, filtered takes sync and the counter clears.
  - If sync == filtered, the counter clears.
  - Pulses shorter than FILTER_LEN cycles at the synchroniser output are suppressed.
  - Latency from pad edge to m_i change = 2 + FILTER_LEN cycles.
- START/STOP detection on filtered levels, using registered previous values (scl_q, sda_q):
  - start_det = scl_q & scl & sda_q & ~sda.
  - stop_det = scl_q & scl & ~sda_q & sda.
  - If SCL and SDA change in the same cycle, scl_q is still 1 but scl is 0, so no detection occurs.
  - Outputs are registered: a pulse appears 1 cycle after the filtered edge.
- bus_busy:
  - Set on START; cleared on STOP or when stuck_o sets.
  - A repeated START while busy keeps it set.
- Stuck monitor:
  - Counter increments while filtered scl==0 or sda==0, saturating at STUCK_CYCLES.
  - Counter clears when both lines are high.
  - stuck_o sets the cycle the count reaches STUCK_CYCLES.
  - stuck_clr_i has priority over set: it clears stuck_o and zeroes the counter that cycle; the count then restarts.
- enable_i = 0:
  - Both pads released.
  - scl_m_i and sda_m_i forced to 1.
  - Filter and stuck counters held at 0.
  - Detector pulses and bus_busy forced to 0.
  - On re-enable the filters resume from level 1.
- Asynchronous reset mid-transfer returns everything to reset values immediately and releases the pads.

Decomposition:
- Package i2c_pad_pkg holds:
  - FILTER_CNT_W = 4.
  - Default FILTER_LEN and STUCK_CYCLES constants.
  - Pad index constants SCL_IO = 5 and SDA_IO = 6.
- Sub-module i2c_glitch_filter (synchroniser + filter counter, one line) is instantiated twice.
- Edge detection, busy tracking and the stuck monitor stay in the top module.

Test Plan:
1. Reset with pads high -> all outputs at reset values; pad_oeb = 1; m_i = 1.
2. FILTER_LEN=4, 3-cycle low pulse on scl_pad_i -> scl_m_i stays 1; 4-cycle low pulse -> scl_m_i goes 0 exactly 6 cycles after the pad edge.
3. SCL high, SDA falls, later SDA rises -> start_det_o pulse, bus_busy_o = 1, then stop_det_o pulse, bus_busy_o = 0; SCL and SDA dropped in the same cycle -> no start_det_o.
4. Master drives scl_m_oen=1, scl_m_o=0 -> scl_pad_oeb_o = 0, scl_pad_o = 0; scl_m_o=1 or oen=0 -> scl_pad_oeb_o = 1.
5. STUCK_CYCLES=100, hold SDA low -> stuck_o rises after 100 filtered-low cycles and bus_busy_o clears; stuck_clr_i while still low -> stuck_o = 0 and reasserts 100 cycles later.
6. Assert rst_n_i low mid-START, and separately drop enable_i mid-transfer -> pads released within the same or next cycle, bus_busy_o = 0, counters = 0.
